// File: rtl/fp_mult_pkg.sv
// Shared types and helpers for the floating-point multiplier result sink.
//   fp_class_t  : packed class flags {nan, inf, zero, sub}; at most one bit set
//   fp_classify : builds the class from pre-reduced exponent/mantissa facts
//   FP32_N/ES   : IEEE-754 single-precision word and exponent widths
package fp_mult_pkg;

    localparam int FP32_N  = 32;
    localparam int FP32_ES = 8;

    typedef struct packed {
        logic nan;
        logic inf;
        logic zero;
        logic sub;
    } fp_class_t;

    // Reductions are done by the caller so the function stays width independent.
    function automatic fp_class_t fp_classify(input logic exp_ones,
                                              input logic exp_zero,
                                              input logic man_nz);
        fp_class_t c;
        c      = '0;
        c.nan  = exp_ones &  man_nz;
        c.inf  = exp_ones & ~man_nz;
        c.zero = exp_zero & ~man_nz;
        c.sub  = exp_zero &  man_nz;
        return c;
    endfunction

endpackage

// File: rtl/fp_mult_result_sink_if.sv
// Handshake bundle between the multiplier issuer, the result sink and the
// downstream consumer.
//   in_valid/in_ready : issue handshake (credit based, in_ready is a grant)
//   r                 : multiplier result, meaningful only in the aligned cycle
//   out_valid/out_ready/out_data/out_flags : FIFO head towards the consumer
// Modports: master = issuer/consumer side, slave = result sink.
interface fp_mult_result_sink_if #(parameter int N = 32);
    import fp_mult_pkg::*;

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] r;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    fp_class_t    out_flags;

    modport master (
        output in_valid, r, out_ready,
        input  in_ready, out_valid, out_data, out_flags
    );

    modport slave (
        input  in_valid, r, out_ready,
        output in_ready, out_valid, out_data, out_flags
    );

endinterface

// File: rtl/fp_result_fifo.sv
// Synchronous FIFO holding {flags, data} words for the result sink.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset (pointers/count only)
//   push, push_data : write request; dropped when full unless a pop coincides
//   pop             : read request; ignored when empty
//   head            : current head word, forced to zero while empty
//   empty, full     : status
//   count           : occupancy 0..DEPTH
module fp_result_fifo #(
    parameter int W     = 36,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop frees the slot this cycle, so a full FIFO may still take a push.
    assign do_push = push && (!full || do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries data only and needs no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fp_mult_result_sink.sv
// Result sink for a fixed-latency floating-point multiplier: realigns the
// issue valid with the product, classifies it and buffers {class, result}.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   bus (slave)   : in_valid/in_ready/r issue side, out_* FIFO head side
//   clr_sticky    : synchronous clear of sticky_flags (and counters)
//   sticky_flags  : OR of the classes of every accepted write
//   overflow_err  : a write arrived while full with no pop; held until reset
//   cnt_nan/inf/zero/sub : 16-bit saturating class counters, present only
//                   when FP_MULT_RESULT_STATS_EN is defined
module fp_mult_result_sink
    import fp_mult_pkg::*;
#(
    parameter int N     = FP32_N,
    parameter int ES    = FP32_ES,
    parameter int LAT   = 3,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    fp_mult_result_sink_if.slave  bus,
    input  logic                  clr_sticky,
    output fp_class_t             sticky_flags,
    output logic                  overflow_err
`ifdef FP_MULT_RESULT_STATS_EN
    ,
    output logic [15:0]           cnt_nan,
    output logic [15:0]           cnt_inf,
    output logic [15:0]           cnt_zero,
    output logic [15:0]           cnt_sub
`endif
);
    localparam int SUM_W = $clog2(DEPTH + LAT + 1);

    logic [LAT-1:0]          vld_p;
    logic                    wr_p;
    logic [ES-1:0]           exp_p;
    logic [N-2-ES:0]         man_p;
    fp_class_t               cls_p;
    logic                    pop;
    logic                    wr_ok;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic [$clog2(DEPTH):0]  fifo_count;
    logic [N+3:0]            fifo_head;
    logic [SUM_W-1:0]        credit_used;

    // Issue -> aligned stage: in_valid travels LAT cycles next to the multiplier.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= bus.in_valid;
            for (int i = 1; i < LAT; i++) vld_p[i] <= vld_p[i-1];
        end
    end

    // Aligned stage: product is present on r, classify and write.
    assign wr_p  = vld_p[LAT-1];
    assign exp_p = bus.r[N-2 -: ES];
    assign man_p = bus.r[N-2-ES:0];
    assign cls_p = fp_classify(&exp_p, ~|exp_p, |man_p);

    assign pop   = bus.out_valid && bus.out_ready;
    assign wr_ok = wr_p && (!fifo_full || pop);

    fp_result_fifo #(
        .W     (N + 4),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_p),
        .push_data ({cls_p, bus.r}),
        .pop       (pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    assign bus.out_valid = !fifo_empty;
    assign bus.out_flags = fifo_head[N+3:N];
    assign bus.out_data  = fifo_head[N-1:0];

    // Credits: every in-flight valid already owns a FIFO slot. A pop this cycle
    // is only seen through fifo_count next cycle, which keeps this conservative.
    always_comb begin
        credit_used = SUM_W'(fifo_count);
        for (int i = 0; i < LAT; i++) credit_used = credit_used + SUM_W'(vld_p[i]);
        bus.in_ready = (credit_used < SUM_W'(DEPTH));
    end

    // A coincident write survives the clear so its class is not lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_flags <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (clr_sticky)  sticky_flags <= wr_ok ? cls_p : '0;
            else if (wr_ok)  sticky_flags <= sticky_flags | cls_p;
            if (wr_p && fifo_full && !pop) overflow_err <= 1'b1;
        end
    end

`ifdef FP_MULT_RESULT_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] c, input logic hit);
        return (hit && (c != 16'hFFFF)) ? c + 16'd1 : c;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_nan  <= '0;
            cnt_inf  <= '0;
            cnt_zero <= '0;
            cnt_sub  <= '0;
        end else if (clr_sticky) begin
            cnt_nan  <= {15'd0, wr_ok & cls_p.nan};
            cnt_inf  <= {15'd0, wr_ok & cls_p.inf};
            cnt_zero <= {15'd0, wr_ok & cls_p.zero};
            cnt_sub  <= {15'd0, wr_ok & cls_p.sub};
        end else begin
            cnt_nan  <= sat_inc(cnt_nan,  wr_ok & cls_p.nan);
            cnt_inf  <= sat_inc(cnt_inf,  wr_ok & cls_p.inf);
            cnt_zero <= sat_inc(cnt_zero, wr_ok & cls_p.zero);
            cnt_sub  <= sat_inc(cnt_sub,  wr_ok & cls_p.sub);
        end
    end
`endif

endmodule

// File: doc/fp_mult_result_sink.md
FP_MULT_RESULT_SINK -- requirements
Module: fp_mult_result_sink

Interface
REQ-001 Parameter N, default 32: floating-point word width.
REQ-002 Parameter ES, default 8: exponent field width.
REQ-003 Parameter LAT, default 3: fixed latency of the upstream multiplier in cycles, LAT >= 1.
REQ-004 Parameter DEPTH, default 4: output FIFO entries, power of two, DEPTH >= 2.
REQ-005 Port clk, input, 1: single clock, all logic on its rising edge.
REQ-006 Port rst, input, 1: reset, asynchronous, active-high.
REQ-007 Port in_valid, input, 1: operands are presented to the multiplier this cycle.
REQ-008 Port in_ready, output, 1: block can accept a product LAT cycles later; the issuer shall only assert in_valid when in_ready is high.
REQ-009 Port r, input, N: multiplier result, sampled only in the aligned cycle.
REQ-010 Port out_valid, output, 1: FIFO head is valid.
REQ-011 Port out_ready, input, 1: consumer accepts the head.
REQ-012 Port out_data, output, N: FIFO head result.
REQ-013 Port out_flags, output, 4: head class {nan, inf, zero, sub}.
REQ-014 Port sticky_flags, output, 4: OR of all classes written since reset or clear.
REQ-015 Port clr_sticky, input, 1: synchronous clear of sticky_flags and counters.

Function
REQ-016 in_valid shall be delayed through an LAT-stage valid shift register. When the last stage is 1, r shall be written to the FIFO with its class.
REQ-017 Classification: exp = r[N-2:N-1-ES], man = r[N-2-ES:0].
- nan: exp all ones, man != 0.
- inf: exp all ones, man == 0.
- zero: exp == 0, man == 0.
- sub: exp == 0, man != 0.
- Otherwise 0000. Exactly one or zero bits are set.
REQ-018 Latency: in_valid high in cycle t gives out_valid high in cycle t+LAT+1 when the FIFO was empty.
REQ-019 in_ready shall be 1 when (FIFO occupancy + in-flight valid count) < DEPTH. This credit scheme is conservative: a pop in the same cycle does not raise in_ready until the next cycle.
REQ-020 Overflow is impossible under REQ-008. If a write occurs while full, the write shall be dropped and overflow_err shall assert, sticky until reset.
REQ-021 A pop occurs when out_valid && out_ready. Push and pop in the same cycle shall be legal at any occupancy, including full and empty; occupancy is unchanged.
REQ-022 Pointers shall wrap modulo DEPTH. out_data and out_flags shall be stable while out_valid && !out_ready.
REQ-023 sticky_flags shall OR in the class of each write. If clr_sticky and a write coincide, the result shall equal the written class only.

Reset
REQ-024 rst shall clear the valid pipe, the FIFO pointers and occupancy, sticky_flags, overflow_err and the counters.
REQ-025 After rst: out_valid = 0, in_ready = 1, out_data = 0, out_flags = 0.
REQ-026 Reset mid-operation shall discard in-flight products. Products arriving after rst deasserts whose valid was issued before reset shall be ignored.

Configuration
REQ-027 Macro FP_MULT_RESULT_STATS_EN, when defined, shall add four 16-bit saturating counters (cnt_nan, cnt_inf, cnt_zero, cnt_sub) as outputs. Each increments once per write of its class and clears on clr_sticky.
REQ-028 Without the macro, the counter ports and logic shall be absent. All other behaviour shall be identical.

Structure
REQ-029 Package fp_mult_pkg shall hold:
- fp_class_t (4-bit packed struct nan/inf/zero/sub)
- the classification function
- constants FP32_N = 32 and FP32_ES = 8.
REQ-030 There shall be one sub-module, fp_result_fifo, a parameterised synchronous FIFO carrying {flags, data}. Valid alignment and classification stay in the top.

Verification
REQ-031 Scenario: LAT=3, in_valid at cycle 10, r=32'h3F800000 at cycle 13 -> out_valid at 14, out_data=3F800000, out_flags=0000.
REQ-032 Scenario: four products 7FC00000, 7F800000, 00000000, 00000001 with out_ready=0 -> out_flags 1000, 0100, 0010, 0001 in order, sticky_flags=1111, in_ready=0 after the fourth issue.
REQ-033 Scenario: FIFO full, out_ready=1, and a push aligned in the same cycle -> occupancy stays DEPTH, no data lost, overflow_err=0.
REQ-034 Scenario: rst pulsed while 2 products are in flight and 1 is buffered -> out_valid=0, in_ready=1; the late aligned r values are never output.
REQ-035 Scenario: clr_sticky coinciding with a write of 7F800000 -> sticky_flags=0100 the next cycle.
REQ-036 Scenario: with FP_MULT_RESULT_STATS_EN, 70000 zero-class writes -> cnt_zero=16'hFFFF (saturated), other counters 0.
